// File: rtl/sirene_sequencer.sv
// End-of-shift siren sequencer: qualify, sound, hold off, re-arm, count.
// Optional blinking siren output selected by macro SIRENE_BLINK_EN.
module sirene_sequencer #(
   parameter int QUAL_CYCLES    = 3,
   parameter int ALARM_CYCLES   = 16,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int BLINK_HALF     = 2,
   parameter int NBITS_CNT      = 8
) (
   input  logic                 clk_2,
   input  logic                 reset_n,
   input  logic                 noite,
   input  logic                 paradas,
   input  logic                 sexta,
   input  logic                 producao,
   input  logic                 ack,
   output logic                 sirene,
   output logic                 busy,
   output logic [1:0]           state,
   output logic [7:0]           timer,
   output logic [NBITS_CNT-1:0] alarm_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUAL  = 2'd1,
      ALARM = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] QUAL_LAST  = 8'(QUAL_CYCLES - 1);
   localparam logic [7:0] ALARM_LAST = 8'(ALARM_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_CYCLES - 1);

   state_t               state_q, state_d;
   logic [7:0]           timer_q, timer_d;
   logic [NBITS_CNT-1:0] count_q, count_d;
   logic                 trigger;

   assign trigger = (noite & paradas) | (sexta & producao & paradas);

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (trigger) begin
               state_d = QUAL;
               timer_d = 8'd1;
            end
         end
         QUAL: begin
            if (!trigger) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == QUAL_LAST) begin
               state_d = ALARM;
               timer_d = '0;
               if (count_q != '1)
                  count_d = count_q + 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ALARM: begin
            // Operator acknowledge wins over the timeout on the same edge
            if (ack || timer_q == ALARM_LAST) begin
               state_d = HOLD;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         HOLD: begin
            if (timer_q < HOLD_LAST) begin
               timer_d = timer_q + 8'd1;
            end else if (!trigger) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

`ifdef SIRENE_BLINK_EN
   localparam logic [7:0] BLINK_DIV = 8'(BLINK_HALF);
   logic [7:0] blink_phase;

   assign blink_phase = timer_q / BLINK_DIV;
   assign sirene      = (state_q == ALARM) && !blink_phase[0];
`else
   assign sirene = (state_q == ALARM);
`endif

   assign busy        = (state_q != IDLE);
   assign state       = state_q;
   assign timer       = timer_q;
   assign alarm_count = count_q;

endmodule

// File: tb/tb_sirene_sequencer.sv
// Self-checking bench for sirene_sequencer against a behavioural model.
// A second instance with a 2-bit counter covers count saturation.
module tb_sirene_sequencer;

   localparam int QC = 3;
   localparam int AC = 16;
   localparam int HC = 8;
   localparam int BH = 2;

   logic       clk_2 = 1'b0;
   logic       reset_n = 1'b0;
   logic       noite = 0, paradas = 0, sexta = 0, producao = 0, ack = 0;
   logic       sirene, busy, sirene2, busy2;
   logic [1:0] state, state2;
   logic [7:0] timer, timer2;
   logic [7:0] alarm_count;
   logic [1:0] alarm_count2;

   int errors = 0;
   int checks = 0;

   int m_st, m_t, m_cnt;

   sirene_sequencer #(
      .QUAL_CYCLES(QC), .ALARM_CYCLES(AC), .HOLDOFF_CYCLES(HC),
      .BLINK_HALF(BH), .NBITS_CNT(8)
   ) dut (
      .clk_2(clk_2), .reset_n(reset_n), .noite(noite),
      .paradas(paradas), .sexta(sexta), .producao(producao),
      .ack(ack), .sirene(sirene), .busy(busy), .state(state),
      .timer(timer), .alarm_count(alarm_count)
   );

   sirene_sequencer #(
      .QUAL_CYCLES(QC), .ALARM_CYCLES(AC), .HOLDOFF_CYCLES(HC),
      .BLINK_HALF(BH), .NBITS_CNT(2)
   ) dut2 (
      .clk_2(clk_2), .reset_n(reset_n), .noite(noite),
      .paradas(paradas), .sexta(sexta), .producao(producao),
      .ack(ack), .sirene(sirene2), .busy(busy2), .state(state2),
      .timer(timer2), .alarm_count(alarm_count2)
   );

   always #5 clk_2 = ~clk_2;

   function automatic bit trig_f();
      return (noite && paradas) || (sexta && producao && paradas);
   endfunction

   function automatic bit exp_sir(int st, int t);
      if (st != 2) return 1'b0;
`ifdef SIRENE_BLINK_EN
      return ((t / BH) % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   // Phases: 0 idle, 1 qualifying, 2 sounding, 3 holding off
   task automatic model_edge(input bit trg, input bit a);
      case (m_st)
         0: if (trg) begin m_st = 1; m_t = 1; end
         1: begin
            if (!trg) begin
               m_st = 0; m_t = 0;
            end else if (m_t + 1 == QC) begin
               m_st = 2; m_t = 0;
               if (m_cnt < 255) m_cnt++;
            end else begin
               m_t++;
            end
         end
         2: begin
            if (a || m_t + 1 == AC) begin
               m_st = 3; m_t = 0;
            end else begin
               m_t++;
            end
         end
         default: begin
            if (m_t + 1 < HC) m_t++;
            else if (!trg) begin m_st = 0; m_t = 0; end
         end
      endcase
   endtask

   task automatic check(input string name);
      int c2;
      bit es;
      c2 = (m_cnt > 3) ? 3 : m_cnt;
      es = exp_sir(m_st, m_t);
      checks++;
      if (state !== 2'(m_st) || timer !== 8'(m_t) ||
          sirene !== es || busy !== (m_st != 0) ||
          alarm_count !== 8'(m_cnt) || alarm_count2 !== 2'(c2) ||
          state2 !== 2'(m_st) || timer2 !== 8'(m_t)) begin
         errors++;
         $display("FAIL %s: got st=%0d t=%0d sir=%0b busy=%0b cnt=%0d cnt2=%0d st2=%0d t2=%0d exp st=%0d t=%0d sir=%0b cnt=%0d cnt2=%0d",
                  name, state, timer, sirene, busy, alarm_count,
                  alarm_count2, state2, timer2, m_st, m_t, es, m_cnt, c2);
      end
   endtask

   task automatic set_in(input bit n, input bit p, input bit s,
                         input bit pr, input bit a);
      noite = n; paradas = p; sexta = s; producao = pr; ack = a;
   endtask

   task automatic step(input string name);
      bit trg, a;
      trg = trig_f();
      a = ack;
      @(posedge clk_2);
      #1;
      model_edge(trg, a);
      check(name);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      m_st = 0; m_t = 0; m_cnt = 0;
      check("reset");
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit n, p, s, pr, a;
      int st, t, cnt;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int hi;
      vecs[0]  = '{1,1,0,0,0, 1,1,0};
      vecs[1]  = '{1,1,0,0,0, 1,2,0};
      vecs[2]  = '{1,0,0,0,0, 0,0,0};
      vecs[3]  = '{0,0,0,0,0, 0,0,0};
      vecs[4]  = '{0,1,1,1,0, 1,1,0};
      vecs[5]  = '{0,1,1,1,0, 1,2,0};
      vecs[6]  = '{0,1,1,1,0, 2,0,1};
      vecs[7]  = '{0,1,1,1,0, 2,1,1};
      vecs[8]  = '{0,0,1,1,0, 2,2,1};
      vecs[9]  = '{0,0,1,1,1, 3,0,1};
      vecs[10] = '{0,1,1,1,1, 3,1,1};

      #2;
      do_reset();

      // Table: abort during qualify, Friday alarm, ack to hold
      foreach (vecs[i]) begin
         bit es;
         set_in(vecs[i].n, vecs[i].p, vecs[i].s, vecs[i].pr, vecs[i].a);
         @(posedge clk_2);
         #1;
         es = exp_sir(vecs[i].st, vecs[i].t);
         checks++;
         if (state !== 2'(vecs[i].st) || timer !== 8'(vecs[i].t) ||
             sirene !== es || alarm_count !== 8'(vecs[i].cnt) ||
             busy !== (vecs[i].st != 0)) begin
            errors++;
            $display("FAIL vec%0d: got st=%0d t=%0d sir=%0b cnt=%0d exp st=%0d t=%0d sir=%0b cnt=%0d",
                     i, state, timer, sirene, alarm_count,
                     vecs[i].st, vecs[i].t, es, vecs[i].cnt);
         end
      end

      // Full timed alarm with trigger held, then freeze and re-arm
      do_reset();
      set_in(1, 1, 0, 0, 0);
      hi = 0;
      for (int i = 0; i < 3 + AC + HC + 4; i++) begin
         step("timed");
         if (sirene) hi++;
      end
      checks++;
      if (hi != ((AC + 1) / 2) * 0 + AC && exp_sir(2, 2) ||
          (!exp_sir(2, 2) && hi != 8)) begin
         errors++;
         $display("FAIL siren_len: got %0d cycles", hi);
      end
      checks++;
      if (state !== 2'd3 || timer !== 8'(HC - 1)) begin
         errors++;
         $display("FAIL hold_freeze: got st=%0d t=%0d exp st=3 t=%0d",
                  state, timer, HC - 1);
      end
      set_in(1, 0, 0, 0, 0);
      step("rearm");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rearm_busy: got %0b exp 0", busy);
      end

      // Asynchronous reset in the middle of an alarm
      set_in(1, 1, 0, 0, 0);
      while (!(m_st == 2 && m_t == 9)) step("to_t9");
      #2;
      reset_n = 1'b0;
      #1;
      m_st = 0; m_t = 0; m_cnt = 0;
      check("async_reset");
      #1;
      reset_n = 1'b1;

      // Five acked alarms: saturating 2-bit counter
      for (int k = 0; k < 5; k++) begin
         set_in(1, 1, 0, 0, 0);
         for (int i = 0; i < QC; i++) step("sat_qual");
         set_in(1, 1, 0, 0, 1);
         step("sat_ack");
         set_in(0, 0, 0, 0, 1);
         for (int i = 0; i < HC; i++) step("sat_hold");
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit p;
         p = ($urandom_range(0, 9) < 8);
         set_in(1'($urandom), p, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 15) == 0));
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sirene_sequencer.md
Name: sirene_sequencer

Overview:
- Sequenced controller for the end-of-shift siren.
- Qualifies the raw siren condition from the four shift inputs (night, stoppages, Friday, production) over several clock cycles, then sounds the siren for a bounded time with operator acknowledge.
- Enforces a hold-off and a re-arm rule, and counts alarm events.
- Sits between the switch inputs and the LED/display outputs of top.

Parameters:
- QUAL_CYCLES, 3: consecutive sampled-high cycles of trigger required to start an alarm; legal range 2..255.
- ALARM_CYCLES, 16: maximum siren duration in cycles; legal range 1..256.
- HOLDOFF_CYCLES, 8: minimum cycles in HOLD before re-arm; legal range 1..256.
- BLINK_HALF, 2: blink half-period in cycles; used only with the optional feature; 1..128.
- NBITS_CNT, 8: width of alarm_count.

Ports:
- clk_2 in 1: system clock; all state changes on its rising edge.
- reset_n in 1: asynchronous, active-low reset.
- noite in 1: night shift.
- paradas in 1: machine stoppages.
- sexta in 1: Friday.
- producao in 1: production target met.
- ack in 1: operator silence request, level-sampled.
- sirene out 1: siren drive to LED.
- busy out 1: high when state is not IDLE.
- state out 2: current FSM state for display.
- timer out 8: current state timer for display.
- alarm_count out NBITS_CNT: number of alarms started, saturating.

Behaviour:
- trigger = (noite & paradas) | (sexta & producao & paradas); purely combinational, sampled at each clk_2 edge.
- Registers are state, timer and alarm_count.
- State encoding: IDLE=0, QUAL=1, ALARM=2, HOLD=3.
- Reset (reset_n low, acts immediately without a clock edge): state=IDLE, timer=0, alarm_count=0, so sirene=0 and busy=0. Reset mid-alarm silences the siren at once. The first edge after reset_n rises evaluates from IDLE.
- IDLE:
  - timer=0.
  - trigger=1 -> QUAL, timer=1.
- QUAL:
  - trigger=0 -> IDLE, timer=0. No count change.
  - Else if timer==QUAL_CYCLES-1 -> ALARM, timer=0, alarm_count+1.
  - Else timer+1.
  - Net effect: ALARM is entered after the QUAL_CYCLES-th consecutive edge sampling trigger=1.
- ALARM:
  - ack=1 -> HOLD, timer=0. ack has priority over timeout.
  - Else if timer==ALARM_CYCLES-1 -> HOLD, timer=0.
  - Else timer+1.
  - Trigger falling does NOT end an alarm.
- HOLD:
  - If timer<HOLDOFF_CYCLES-1, timer+1.
  - At timer==HOLDOFF_CYCLES-1: trigger=0 -> IDLE, timer=0. trigger=1 -> stay HOLD with timer frozen at HOLDOFF_CYCLES-1. Re-arm requires trigger to be sampled low.
  - ack is ignored.
- sirene is a Moore output, a function of registered state/timer only: 1 iff state==ALARM (without the optional feature). Latency is zero cycles from ALARM entry.
- busy = (state!=IDLE).
- alarm_count saturates at all-ones; no wrap.
- timer is 8 bits unsigned and never exceeds max(param)-1.

Optional Feature:
- Macro SIRENE_BLINK_EN.
- Defined: in ALARM, sirene = ((timer / BLINK_HALF) mod 2 == 0). It starts at 1 on the first ALARM cycle and alternates every BLINK_HALF cycles. It is 0 in all other states.
- Undefined: sirene is steady 1 throughout ALARM, and BLINK_HALF is unused.
- FSM, timing and counts are identical in both builds.

Test Plan:
- Defaults; noite=1, paradas=1 held from edge 0: state=1 after edge 0, 2 after edge 2, sirene=1 for 16 cycles, then HOLD for 8 cycles; alarm_count=1. Trigger still high: HOLD persists with timer=7. Drop paradas: IDLE on the next edge, busy=0.
- noite=1, paradas=1 for 2 edges, then paradas=0: QUAL->IDLE, sirene never 1, alarm_count=0.
- sexta=1, producao=1, paradas=1: ALARM. ack=1 sampled at ALARM timer=5: HOLD next edge, sirene=0, timer=0. ack held during HOLD has no effect.
- reset_n=0 asynchronously at ALARM timer=9: sirene=0, state=0, timer=0, alarm_count=0 before the next clk_2 edge.
- SIRENE_BLINK_EN defined, BLINK_HALF=2: sirene over the 16 ALARM cycles = 1,1,0,0 repeated four times.
- NBITS_CNT=2, five complete alarm/re-arm cycles: alarm_count = 1,2,3,3,3.
